pipe_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage RISC-V pipeline. It takes register-read requests from the decode stage, load/branch/multi-cycle status from EX, and memory-busy status from MEM. From these it produces the per-stage stall vector, the flush pulse and the redirect PC. The IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC register consume its outputs.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 23 ++
 rtl/pipe_hazard_ctrl_if.sv | 50 +++++
 rtl/pipe_hazard_ctrl_hazard_cmp.sv | 17 +
 rtl/pipe_hazard_ctrl.sv | 126 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: stall-vector bit
// positions, stall patterns and sequencer states.
package pipe_hazard_ctrl_pkg;

  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;

  // Each pattern holds every stage up to and including the named one
  localparam logic [5:0] StallNone = 6'b000000;
  localparam logic [5:0] StallId   = 6'b000111;
  localparam logic [5:0] StallEx   = 6'b001111;
  localparam logic [5:0] StallMem  = 6'b011111;

  typedef enum logic {
    StIdle   = 1'b0,
    StMcBusy = 1'b1
  } state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side bundle of the hazard controller: decode/EX/MEM status in,
// stall/flush/redirect out. Perf-counter outputs exist only with PERF_CNT_EN.
interface pipe_hazard_ctrl_if #(
  parameter int MC_CNT_W = 4
`ifdef PERF_CNT_EN
  , parameter int PERF_W = 32
`endif
);

  logic                id_reg1_read_i;
  logic [4:0]          id_reg1_addr_i;
  logic                id_reg2_read_i;
  logic [4:0]          id_reg2_addr_i;
  logic                ex_is_load_i;
  logic [4:0]          ex_write_addr_i;
  logic                ex_branch_i;
  logic [31:0]         ex_branch_target_i;
  logic                ex_mc_start_i;
  logic [MC_CNT_W-1:0] ex_mc_len_i;
  logic                mem_stall_req_i;
  logic [5:0]          stall_o;
  logic                flush_o;
  logic [31:0]         new_pc_o;
  logic                busy_o;
`ifdef PERF_CNT_EN
  logic [PERF_W-1:0]   stall_cycles_o;
  logic [PERF_W-1:0]   flush_count_o;
`endif

  modport master (
    output id_reg1_read_i, id_reg1_addr_i, id_reg2_read_i, id_reg2_addr_i,
           ex_is_load_i, ex_write_addr_i, ex_branch_i, ex_branch_target_i,
           ex_mc_start_i, ex_mc_len_i, mem_stall_req_i,
    input  stall_o, flush_o, new_pc_o, busy_o
`ifdef PERF_CNT_EN
    , input stall_cycles_o, flush_count_o
`endif
  );

  modport slave (
    input  id_reg1_read_i, id_reg1_addr_i, id_reg2_read_i, id_reg2_addr_i,
           ex_is_load_i, ex_write_addr_i, ex_branch_i, ex_branch_target_i,
           ex_mc_start_i, ex_mc_len_i, mem_stall_req_i,
    output stall_o, flush_o, new_pc_o, busy_o
`ifdef PERF_CNT_EN
    , output stall_cycles_o, flush_count_o
`endif
  );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_cmp.sv
// Load-use comparator: flags an ID source register that matches the rd of a
// load in EX. x0 never matches; kept separate so a forwarding unit can reuse it.
module pipe_hazard_ctrl_hazard_cmp (
  input  logic       reg1_read,
  input  logic [4:0] reg1_addr,
  input  logic       reg2_read,
  input  logic [4:0] reg2_addr,
  input  logic       ex_is_load,
  input  logic [4:0] ex_write_addr,
  output logic       hazard
);

  assign hazard = ex_is_load && (ex_write_addr != 5'd0) &&
                  ((reg1_read && (reg1_addr == ex_write_addr)) ||
                   (reg2_read && (reg2_addr == ex_write_addr)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline. Optional perf counters are
// enabled by defining PERF_CNT_EN.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MC_CNT_W = 4
`ifdef PERF_CNT_EN
  , parameter int PERF_W = 32
`endif
) (
  input  logic             clk,
  input  logic             rst,
  pipe_hazard_ctrl_if.slave bus
);

  localparam logic [MC_CNT_W-1:0] McOne = MC_CNT_W'(1);

  state_e              state;
  logic [MC_CNT_W-1:0] mc_cnt;
  logic                branch_pend;
  logic [31:0]         pend_pc;

  logic                load_use;
  logic                blocked;
  logic                mc_stall;
  logic                flush;
  logic [31:0]         flush_pc;
  logic [5:0]          stall_vec;
  logic [MC_CNT_W-1:0] eff_len;

  pipe_hazard_ctrl_hazard_cmp u_hazard_cmp (
    .reg1_read     (bus.id_reg1_read_i),
    .reg1_addr     (bus.id_reg1_addr_i),
    .reg2_read     (bus.id_reg2_read_i),
    .reg2_addr     (bus.id_reg2_addr_i),
    .ex_is_load    (bus.ex_is_load_i),
    .ex_write_addr (bus.ex_write_addr_i),
    .hazard        (load_use)
  );

  assign eff_len = (bus.ex_mc_len_i == '0) ? McOne : bus.ex_mc_len_i;

  // A fresh branch in EX wins over an older pending one when both are ready
  always_comb begin
    blocked  = bus.mem_stall_req_i || (state == StMcBusy);
    mc_stall = (state == StMcBusy) || bus.ex_mc_start_i;
    flush    = !blocked && (bus.ex_branch_i || branch_pend);
    flush_pc = bus.ex_branch_i ? bus.ex_branch_target_i : pend_pc;
    if (bus.mem_stall_req_i)       stall_vec = StallMem;
    else if (mc_stall)             stall_vec = StallEx;
    else if (load_use && !flush)   stall_vec = StallId;
    else                           stall_vec = StallNone;
  end

  always_comb begin
    bus.stall_o  = StallNone;
    bus.flush_o  = 1'b0;
    bus.new_pc_o = '0;
    bus.busy_o   = 1'b0;
    if (rst) begin
      bus.stall_o  = stall_vec;
      bus.flush_o  = flush;
      bus.new_pc_o = flush ? flush_pc : '0;
      bus.busy_o   = |stall_vec;
    end
  end

  // The start cycle itself stalls, so the counter covers the remaining L-1
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= StIdle;
      mc_cnt      <= '0;
      branch_pend <= 1'b0;
      pend_pc     <= '0;
    end else begin
      case (state)
        StIdle: begin
          if (bus.ex_mc_start_i && !bus.mem_stall_req_i && (eff_len > McOne)) begin
            mc_cnt <= eff_len - McOne;
            state  <= StMcBusy;
          end
        end
        StMcBusy: begin
          if (!bus.mem_stall_req_i) begin
            if (mc_cnt <= McOne) begin
              mc_cnt <= '0;
              state  <= StIdle;
            end else begin
              mc_cnt <= mc_cnt - McOne;
            end
          end
        end
        default: state <= StIdle;
      endcase

      if (bus.ex_branch_i && blocked) begin
        pend_pc     <= bus.ex_branch_target_i;
        branch_pend <= 1'b1;
      end else if (flush) begin
        branch_pend <= 1'b0;
      end
    end
  end

`ifdef PERF_CNT_EN
  logic [PERF_W-1:0] stall_cycles;
  logic [PERF_W-1:0] flush_count;

  // Saturating counters: they stick at all-ones rather than wrap
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (bus.busy_o && (stall_cycles != '1))
        stall_cycles <= stall_cycles + PERF_W'(1);
      if (bus.flush_o && (flush_count != '1))
        flush_count <= flush_count + PERF_W'(1);
    end
  end

  assign bus.stall_cycles_o = stall_cycles;
  assign bus.flush_count_o  = flush_count;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed table-driven bench for pipe_hazard_ctrl, plus a hand-written
// reset-during-multicycle sequence. Checks perf counters when PERF_CNT_EN is set.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.MC_CNT_W(4)) bus ();

  pipe_hazard_ctrl #(.MC_CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       name;
    logic        rst_n;
    logic        r1rd;
    logic [4:0]  r1a;
    logic        r2rd;
    logic [4:0]  r2a;
    logic        ld;
    logic [4:0]  wa;
    logic        br;
    logic [31:0] tgt;
    logic        mcs;
    logic [3:0]  mcl;
    logic        ms;
    logic [5:0]  exp_stall;
    logic        exp_flush;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[$];
  int   compared   = 0;
  int   mismatched = 0;

  function automatic vec_t mk(input string name, input logic [5:0] exp_stall = 6'b0,
                              input logic exp_flush = 1'b0, input logic [31:0] exp_pc = 32'h0,
                              input logic ms = 1'b0, input logic mcs = 1'b0,
                              input logic [3:0] mcl = 4'd0, input logic br = 1'b0,
                              input logic [31:0] tgt = 32'h0, input logic ld = 1'b0,
                              input logic [4:0] wa = 5'd0, input logic r1rd = 1'b0,
                              input logic [4:0] r1a = 5'd0, input logic r2rd = 1'b0,
                              input logic [4:0] r2a = 5'd0, input logic rst_n = 1'b1);
    vec_t v;
    v.name = name;   v.rst_n = rst_n; v.r1rd = r1rd; v.r1a = r1a;
    v.r2rd = r2rd;   v.r2a = r2a;     v.ld = ld;     v.wa = wa;
    v.br = br;       v.tgt = tgt;     v.mcs = mcs;   v.mcl = mcl;
    v.ms = ms;       v.exp_stall = exp_stall;
    v.exp_flush = exp_flush;          v.exp_pc = exp_pc;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    rst                    = v.rst_n;
    bus.id_reg1_read_i     = v.r1rd;
    bus.id_reg1_addr_i     = v.r1a;
    bus.id_reg2_read_i     = v.r2rd;
    bus.id_reg2_addr_i     = v.r2a;
    bus.ex_is_load_i       = v.ld;
    bus.ex_write_addr_i    = v.wa;
    bus.ex_branch_i        = v.br;
    bus.ex_branch_target_i = v.tgt;
    bus.ex_mc_start_i      = v.mcs;
    bus.ex_mc_len_i        = v.mcl;
    bus.mem_stall_req_i    = v.ms;
  endtask

  task automatic checkOutput(input vec_t v);
    compared++;
    if (bus.stall_o !== v.exp_stall) begin
      mismatched++;
      $display("[TB] FAIL %s.stall got %b want %b", v.name, bus.stall_o, v.exp_stall);
    end
    compared++;
    if (bus.flush_o !== v.exp_flush) begin
      mismatched++;
      $display("[TB] FAIL %s.flush got %b want %b", v.name, bus.flush_o, v.exp_flush);
    end
    compared++;
    if (bus.busy_o !== (|v.exp_stall)) begin
      mismatched++;
      $display("[TB] FAIL %s.busy got %b want %b", v.name, bus.busy_o, |v.exp_stall);
    end
    if (v.exp_flush) begin
      compared++;
      if (bus.new_pc_o !== v.exp_pc) begin
        mismatched++;
        $display("[TB] FAIL %s.new_pc got %h want %h", v.name, bus.new_pc_o, v.exp_pc);
      end
    end
  endtask

  task automatic runVec(input vec_t v);
    @(negedge clk);
    applyStimulus(v);
    #1;
    checkOutput(v);
  endtask

  task automatic checkValue(input string name, input logic [31:0] got, input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("[TB] FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  initial begin
    int exp_stall_cycles;
    int exp_flushes;

    // Rows are consecutive cycles; state carries from one row to the next
    vecs.push_back(mk(.name("rst_force"), .ms(1), .mcs(1), .mcl(4'd5), .br(1), .tgt(32'h55),
                      .ld(1), .wa(5'd3), .r1rd(1), .r1a(5'd3), .rst_n(0)));
    vecs.push_back(mk(.name("rst_hold"), .rst_n(0)));
    vecs.push_back(mk(.name("lu_rs1"), .exp_stall(6'b000111), .ld(1), .wa(5'd5), .r1rd(1), .r1a(5'd5)));
    vecs.push_back(mk(.name("lu_clear")));
    vecs.push_back(mk(.name("lu_x0"), .ld(1), .wa(5'd0), .r1rd(1), .r1a(5'd0), .r2rd(1), .r2a(5'd0)));
    vecs.push_back(mk(.name("lu_rs2"), .exp_stall(6'b000111), .ld(1), .wa(5'd7), .r2rd(1), .r2a(5'd7)));
    vecs.push_back(mk(.name("lu_noread"), .ld(1), .wa(5'd7), .r1a(5'd7), .r2a(5'd7)));
    vecs.push_back(mk(.name("lu_notload"), .wa(5'd7), .r1rd(1), .r1a(5'd7)));
    vecs.push_back(mk(.name("lu_diff"), .ld(1), .wa(5'd7), .r1rd(1), .r1a(5'd6)));
    vecs.push_back(mk(.name("br_flush"), .exp_flush(1), .exp_pc(32'h80), .br(1), .tgt(32'h80),
                      .ld(1), .wa(5'd3), .r1rd(1), .r1a(5'd3)));
    vecs.push_back(mk(.name("br_after")));
    vecs.push_back(mk(.name("mc4_c1"), .exp_stall(6'b001111), .mcs(1), .mcl(4'd4)));
    vecs.push_back(mk(.name("mc4_c2"), .exp_stall(6'b001111), .mcs(1), .mcl(4'd9)));
    vecs.push_back(mk(.name("mc4_c3"), .exp_stall(6'b001111)));
    vecs.push_back(mk(.name("mc4_c4"), .exp_stall(6'b001111)));
    vecs.push_back(mk(.name("mc4_done")));
    vecs.push_back(mk(.name("mc0_c1"), .exp_stall(6'b001111), .mcs(1), .mcl(4'd0)));
    vecs.push_back(mk(.name("mc0_done")));
    vecs.push_back(mk(.name("mc1_c1"), .exp_stall(6'b001111), .mcs(1), .mcl(4'd1)));
    vecs.push_back(mk(.name("mc1_done")));
    vecs.push_back(mk(.name("ms_br_c1"), .exp_stall(6'b011111), .ms(1), .br(1), .tgt(32'h100)));
    vecs.push_back(mk(.name("ms_c2"), .exp_stall(6'b011111), .ms(1)));
    vecs.push_back(mk(.name("ms_c3"), .exp_stall(6'b011111), .ms(1)));
    vecs.push_back(mk(.name("ms_flush"), .exp_flush(1), .exp_pc(32'h100)));
    vecs.push_back(mk(.name("ms_after")));
    vecs.push_back(mk(.name("mc6_c1"), .exp_stall(6'b001111), .mcs(1), .mcl(4'd6)));
    vecs.push_back(mk(.name("mc6_c2"), .exp_stall(6'b001111)));
    vecs.push_back(mk(.name("mc6_c3"), .exp_stall(6'b001111)));
    vecs.push_back(mk(.name("mc6_ms1"), .exp_stall(6'b011111), .ms(1), .br(1), .tgt(32'h200)));
    vecs.push_back(mk(.name("mc6_ms2"), .exp_stall(6'b011111), .ms(1)));
    vecs.push_back(mk(.name("mc6_c4"), .exp_stall(6'b001111), .br(1), .tgt(32'h240)));
    vecs.push_back(mk(.name("mc6_c5"), .exp_stall(6'b001111)));
    vecs.push_back(mk(.name("mc6_c6"), .exp_stall(6'b001111)));
    vecs.push_back(mk(.name("mc6_flush"), .exp_flush(1), .exp_pc(32'h240),
                      .ld(1), .wa(5'd9), .r2rd(1), .r2a(5'd9)));
    vecs.push_back(mk(.name("mc6_after")));

    applyStimulus(mk(.name("init"), .rst_n(0)));
    exp_stall_cycles = 0;
    exp_flushes      = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      runVec(vecs[i]);
      if (!vecs[i].rst_n) begin
        exp_stall_cycles = 0;
        exp_flushes      = 0;
      end else begin
        if (|vecs[i].exp_stall) exp_stall_cycles++;
        if (vecs[i].exp_flush)  exp_flushes++;
      end
    end

    runVec(mk(.name("table_tail")));
`ifdef PERF_CNT_EN
    checkValue("perf_stall_cycles", bus.stall_cycles_o, exp_stall_cycles);
    checkValue("perf_flush_count", bus.flush_count_o, exp_flushes);
`endif

    // Reset lands while a multi-cycle op runs and a branch is pending
    runVec(mk(.name("rs_mc_c1"), .exp_stall(6'b001111), .mcs(1), .mcl(4'd6)));
    runVec(mk(.name("rs_mc_br"), .exp_stall(6'b001111), .br(1), .tgt(32'h300)));
    runVec(mk(.name("rs_assert"), .rst_n(0)));
    for (int i = 0; i < 8; i++)
      runVec(mk(.name($sformatf("rs_idle%0d", i))));
`ifdef PERF_CNT_EN
    checkValue("rs_perf_stall_cycles", bus.stall_cycles_o, 0);
    checkValue("rs_perf_flush_count", bus.flush_count_o, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
